// File: rtl/mcp3201_pkg.sv
// Frame constants and state encoding shared by both ends of the MCP3201 link.
package mcp3201_pkg;

    localparam int unsigned MCP3201_BITS  = 12;
    localparam int unsigned NULL_FALL     = 2;
    localparam int unsigned MSB_LAST_FALL = 14;
    localparam int unsigned LSB_LAST_FALL = 25;
    localparam int unsigned FALL_CNT_W    = 5;
    localparam int unsigned FALL_CNT_MAX  = 31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_MSB    = 3'd2,
        ST_LSB    = 3'd3,
        ST_ZERO   = 3'd4
    } state_e;

    // Saturating increment for the SCLK fall counter.
    function automatic logic [FALL_CNT_W-1:0] fall_inc(input logic [FALL_CNT_W-1:0] cnt);
        return (cnt == FALL_CNT_W'(FALL_CNT_MAX)) ? cnt : cnt + FALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mcp3201_if.sv
// Pin and sample-side signals of the MCP3201 emulator.
interface mcp3201_if #(
    parameter int unsigned DATA_WIDTH = mcp3201_pkg::MCP3201_BITS
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_req;
    logic                  frame_done;
    logic                  frame_abort;
    logic                  cs_n_pin;
    logic                  sclk_pin;
    logic                  miso_pin;
    logic                  miso_oe;

    modport master (
        output sample_in, cs_n_pin, sclk_pin,
        input  sample_req, frame_done, frame_abort, miso_pin, miso_oe
    );

    modport slave (
        input  sample_in, cs_n_pin, sclk_pin,
        output sample_req, frame_done, frame_abort, miso_pin, miso_oe
    );
endinterface

// File: rtl/mcp3201_emu_pin_sync.sv
// Multi-stage synchronizer plus rise/fall detector for one asynchronous pin.
module pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    // Chain resets low so a pin already low at release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/mcp3201_emu.sv
// MCP3201 device-side emulator: null bit, MSB-first word, LSB-first tail, then zeros.
module mcp3201_emu
    import mcp3201_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = MCP3201_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    mcp3201_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam logic [FALL_CNT_W-1:0] F_NULL     = FALL_CNT_W'(NULL_FALL);
    localparam logic [FALL_CNT_W-1:0] F_MSB_LAST = FALL_CNT_W'(MSB_LAST_FALL);
    localparam logic [FALL_CNT_W-1:0] F_LSB_LAST = FALL_CNT_W'(LSB_LAST_FALL);

    logic cs_rise_c, cs_fall_c, sclk_rise_c, sclk_fall_c;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .pin    (bus.cs_n_pin),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .pin    (bus.sclk_pin),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [FALL_CNT_W-1:0]   fall_q, fall_d, fall_nxt;
    logic                    captured_q, captured_d;
    logic                    miso_q, miso_d;
    logic                    oe_q, oe_d;
    logic                    req_q, req_d;
    logic                    done_q, done_d;
    logic                    abort_q, abort_d;
    logic [IDX_W-1:0]        bit_idx;

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            fall_q     <= '0;
            captured_q <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            fall_q     <= fall_d;
            captured_q <= captured_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            req_q      <= req_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    // Next-state and output logic; a CS rise outranks any SCLK edge in the same cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        fall_d     = fall_q;
        captured_d = captured_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        req_d      = 1'b0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        fall_nxt   = fall_inc(fall_q);
        bit_idx    = '0;

        if (state_q == ST_IDLE) begin
            if (cs_fall_c) begin
                state_d    = ST_SAMPLE;
                fall_d     = '0;
                captured_d = 1'b0;
            end
        end else if (cs_rise_c) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            if (fall_q >= F_MSB_LAST) begin
                done_d = 1'b1;
            end else begin
                abort_d = 1'b1;
            end
        end else begin
            if (sclk_rise_c && !captured_q) begin
                shift_d    = bus.sample_in;
                captured_d = 1'b1;
                req_d      = 1'b1;
            end
            if (sclk_fall_c) begin
                fall_d = fall_nxt;
                unique case (state_q)
                    ST_SAMPLE: begin
                        if (fall_nxt == F_NULL) begin
                            oe_d    = 1'b1;
                            miso_d  = 1'b0;
                            state_d = ST_MSB;
                        end
                    end
                    ST_MSB: begin
                        bit_idx = IDX_W'(F_MSB_LAST - fall_nxt);
                        miso_d  = shift_q[bit_idx];
                        if (fall_nxt == F_MSB_LAST) begin
                            state_d = ST_LSB;
                        end
                    end
                    ST_LSB: begin
                        bit_idx = IDX_W'(fall_nxt - F_MSB_LAST);
                        miso_d  = shift_q[bit_idx];
                        if (fall_nxt == F_LSB_LAST) begin
                            state_d = ST_ZERO;
                        end
                    end
                    ST_ZERO: begin
                        miso_d = 1'b0;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.miso_pin    = miso_q;
    assign bus.miso_oe     = oe_q;
    assign bus.sample_req  = req_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_mcp3201_emu.sv
// Randomized SPI-master bench for mcp3201_emu with a queue-based MISO scoreboard.
module tb_mcp3201_emu;

    localparam int SYNC  = 2;
    localparam int H_MIN = SYNC + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mcp3201_if #(.DATA_WIDTH(12)) bus ();

    mcp3201_emu #(.DATA_WIDTH(12), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;
    bit         mon_en = 1'b0;
    int         cnt_req = 0, cnt_done = 0, cnt_abort = 0;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Datasheet frame: {oe, miso} seen after fall n (before fall 2 the pin is undriven).
    function automatic logic [1:0] model_after_fall(input logic [11:0] code, input int n);
        bit stream[$];
        if (n < 2) return 2'b00;
        stream.push_back(1'b0);
        for (int i = 11; i >= 0; i--) stream.push_back(code[i]);
        for (int i = 1; i <= 11; i++) stream.push_back(code[i]);
        if (n - 2 < stream.size()) return {1'b1, stream[n-2]};
        return 2'b10;
    endfunction

    // Master samples MISO at each SCLK rise and at the CS rise ending the frame.
    always @(posedge bus.sclk_pin or posedge bus.cs_n_pin) begin
        if (mon_en) begin
            check("mon_queue_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("miso_oe_pin", int'({bus.miso_oe, bus.miso_pin}), int'(mon_e));
            end
        end
    end

    always @(negedge clk) begin
        if (bus.sample_req)  cnt_req++;
        if (bus.frame_done)  cnt_done++;
        if (bus.frame_abort) cnt_abort++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input logic [11:0] code, input int nclk, input int h,
                             input bit change, input logic [11:0] late_code);
        int r0, d0, a0;
        r0 = cnt_req; d0 = cnt_done; a0 = cnt_abort;
        bus.sample_in = code;
        exp_q.delete();
        mon_en = 1'b1;
        bus.cs_n_pin = 1'b0;
        tick(h);
        for (int k = 1; k <= nclk; k++) begin
            exp_q.push_back(model_after_fall(code, k - 1));
            bus.sclk_pin = 1'b1;
            tick(h);
            if (change && k == 1) begin
                check("req_before_change", cnt_req - r0, 1);
                bus.sample_in = late_code;
            end
            bus.sclk_pin = 1'b0;
            tick(h);
        end
        exp_q.push_back(model_after_fall(code, nclk));
        bus.cs_n_pin = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        check("oe_off_after_cs", int'(bus.miso_oe), 0);
        tick(h);
        check("mon_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        check("sample_req_cnt", cnt_req - r0, (nclk > 0) ? 1 : 0);
        check("frame_done_cnt", cnt_done - d0, (nclk >= 14) ? 1 : 0);
        check("frame_abort_cnt", cnt_abort - a0, (nclk < 14) ? 1 : 0);
    endtask

    initial begin
        int r0, d0, a0, sel, nclk;
        bus.cs_n_pin  = 1'b1;
        bus.sclk_pin  = 1'b0;
        bus.sample_in = '0;
        tick(3);
        check("rst_miso_oe", int'(bus.miso_oe), 0);
        check("rst_miso_pin", int'(bus.miso_pin), 0);
        check("rst_pulses", int'({bus.sample_req, bus.frame_done, bus.frame_abort}), 0);
        rst = 1'b1;
        tick(5);

        run_frame(12'h801, 26, 8, 1'b0, 12'h000);
        run_frame(12'h123, 26, 6, 1'b1, 12'hFFF);
        run_frame(12'h5A3, 8, 7, 1'b0, 12'h000);
        run_frame(12'h5A3, 26, 7, 1'b0, 12'h000);
        run_frame(12'hA5C, 14, 5, 1'b0, 12'h000);

        // Reset in the middle of a frame, released with CS still low.
        bus.sample_in = 12'h3C3;
        bus.cs_n_pin  = 1'b0;
        tick(8);
        for (int k = 1; k <= 6; k++) begin
            bus.sclk_pin = 1'b1; tick(8);
            bus.sclk_pin = 1'b0; tick(8);
        end
        check("oe_before_reset", int'(bus.miso_oe), 1);
        rst = 1'b0;
        #1;
        check("oe_in_reset", int'(bus.miso_oe), 0);
        check("miso_in_reset", int'(bus.miso_pin), 0);
        tick(3);
        rst = 1'b1;
        r0 = cnt_req; d0 = cnt_done; a0 = cnt_abort;
        for (int k = 1; k <= 4; k++) begin
            bus.sclk_pin = 1'b1; tick(8);
            check("oe_after_reset", int'(bus.miso_oe), 0);
            bus.sclk_pin = 1'b0; tick(8);
            check("oe_after_reset_fall", int'(bus.miso_oe), 0);
        end
        bus.cs_n_pin = 1'b1;
        tick(8);
        check("req_after_reset", cnt_req - r0, 0);
        check("pulses_after_reset", (cnt_done - d0) + (cnt_abort - a0), 0);
        run_frame(12'h3C3, 26, 8, 1'b0, 12'h000);

        // SCLK activity with CS high must be ignored.
        r0 = cnt_req; d0 = cnt_done; a0 = cnt_abort;
        for (int k = 0; k < 10; k++) begin
            bus.sclk_pin = 1'b1; tick(6);
            check("cs_high_oe", int'(bus.miso_oe), 0);
            bus.sclk_pin = 1'b0; tick(6);
        end
        check("cs_high_req", cnt_req - r0, 0);
        check("cs_high_done", cnt_done - d0, 0);
        check("cs_high_abort", cnt_abort - a0, 0);

        repeat (14) begin
            sel = $urandom_range(3, 0);
            case (sel)
                0:       nclk = 26;
                1:       nclk = 14;
                2:       nclk = 13;
                default: nclk = $urandom_range(30, 0);
            endcase
            run_frame(12'($urandom), nclk, $urandom_range(10, H_MIN),
                      1'($urandom_range(1, 0)) && (nclk > 0), 12'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
